uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The module SHALL have parameter DATA_BITS, default 8, giving the data bits per frame (legal 5..9).
REQ-002 The module SHALL have parameter OVERSAMPLE, default 16, giving baud ticks per bit (even, legal 8..16).
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 8, giving the receive word capacity (power of two, legal 2..64).
REQ-004 The module SHALL have parameter DIV_WIDTH, default 16, giving the width of the baud divisor.
REQ-005 The module SHALL have one clock and a synchronous, active-high reset: clk input 1 system clock; rst input 1 synchronous reset, active-high.
REQ-006 The module SHALL provide: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 The module SHALL provide: baud_div  input  DIV_WIDTH  tick divisor; tick period is baud_div+1 clk cycles.
REQ-008 The module SHALL provide: parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-009 The module SHALL provide: rd_en  input  1  pop request for the head word.
REQ-010 The module SHALL provide: clr_ovr  input  1  clears the overrun flag.
REQ-011 The module SHALL provide: rx_data  output  DATA_BITS  head-word data.
REQ-012 The module SHALL provide: rx_valid  output  1  FIFO not empty.
REQ-013 The module SHALL provide: frame_err  output  1  head word stop bit read 0.
REQ-014 The module SHALL provide: parity_err  output  1  head word parity mismatch.
REQ-015 The module SHALL provide: overrun  output  1  sticky; a word was dropped.
REQ-016 The module SHALL provide: fifo_count  output  clog2(FIFO_DEPTH)+1  words held.

Function
REQ-017 The tick counter SHALL count 0..baud_div and pulse tick for one clk when it equals baud_div, then wrap to 0; baud_div=0 SHALL give a tick every clk.
REQ-018 rx SHALL pass through a two-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-019 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP, together with a per-tick oversample counter os and a bit counter.
REQ-020 IDLE: after the synchronized rx has been seen high, a tick with rx=0 SHALL enter START with os=0.
REQ-021 START: at os=OVERSAMPLE/2-1, rx=0 SHALL enter DATA with os=0; rx=1 SHALL count as a glitch and return to IDLE with no FIFO write.
REQ-022 DATA: each bit SHALL be sampled when os=OVERSAMPLE-1, LSB first; after DATA_BITS samples the FSM SHALL go to PARITY if parity is enabled, else to STOP.
REQ-023 PARITY: the bit SHALL be sampled at os=OVERSAMPLE-1; for even parity, the XOR of the data and parity bits must be 0, otherwise 1; a mismatch SHALL set the word's parity_err bit.
REQ-024 STOP: the bit SHALL be sampled at os=OVERSAMPLE-1; rx=0 SHALL set the word's frame_err bit; the FSM SHALL write {parity_err, frame_err, data} to the FIFO on that clock edge and return to IDLE.
REQ-025 After a frame_err, IDLE SHALL NOT accept a new start until the synchronized rx has been high for at least one tick (break handling).
REQ-026 The FIFO SHALL be show-ahead: rx_data, frame_err and parity_err SHALL reflect the head word whenever rx_valid=1, and SHALL be 0 when the FIFO is empty.
REQ-027 rx_valid SHALL rise on the clk following the FIFO write; latency SHALL be one clk from the stop-bit sample.
REQ-028 rd_en with rx_valid=1 SHALL pop one word; rd_en with rx_valid=0 SHALL be ignored.
REQ-029 A write when full without a same-cycle pop SHALL drop the new word and set overrun; a write and pop in the same cycle when full SHALL store the new word.
REQ-030 A simultaneous write and pop SHALL leave fifo_count unchanged.
REQ-031 overrun SHALL stay set until clr_ovr=1; if clr_ovr coincides with a new drop, set SHALL take priority.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range from 0 to FIFO_DEPTH.
REQ-033 baud_div, parity_mode or OVERSAMPLE changes mid-frame SHALL produce undefined data for that frame only, and SHALL NOT lock up the FSM.

Reset
REQ-034 On rst=1 at a clk edge, the FSM SHALL go to IDLE, all counters and FIFO pointers SHALL clear, and the synchronizer flops SHALL be set to 1.
REQ-035 On reset, rx_data, rx_valid, frame_err, parity_err, overrun and fifo_count SHALL all be 0.
REQ-036 Reset asserted mid-frame SHALL discard the partial frame; the first start is accepted only after rx has been seen high following reset release.

Verification
REQ-037 With baud_div=0, parity none, send 0xA5 with a valid stop -> rx_valid=1 and rx_data=0xA5, frame_err=0, parity_err=0.
REQ-038 With even parity, send 0x03 with parity bit 1 -> parity_err=1 and rx_data=0x03; with parity bit 0 -> parity_err=0.
REQ-039 Send 0x55 with stop=0 and hold rx low for 3 bit-times, then high -> one word with frame_err=1, and no second word until rx has gone high.
REQ-040 A 4-tick low glitch on an idle line -> fifo_count stays 0 and the FSM returns to IDLE.
REQ-041 Send 9 frames with no reads (FIFO_DEPTH=8) -> fifo_count=8 and overrun=1, and 8 pops return the first 8 bytes in order; after clr_ovr -> overrun=0.
REQ-042 Assert rst after bit 4 of a frame -> all outputs are 0, and the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with optional parity, break handling and a
// show-ahead receive FIFO carrying per-word frame/parity error flags.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          rd_en,
    input  logic                          clr_ovr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OS_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    assign tick = (div_cnt == baud_div);

    // The >= wrap keeps the counter from running away if baud_div shrinks mid-count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt >= baud_div) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic sync_a, sync_b, rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= rx;
            sync_b <= sync_a;
        end
    end

    assign rx_s = sync_b;

    state_t                 state, state_n;
    logic [OS_W-1:0]        os, os_n;
    logic [BIT_W-1:0]       bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic                   perr, perr_n;
    logic                   armed, armed_n;
    logic                   wr_en;
    logic [WORD_W-1:0]      wr_word;
    logic                   par_en, par_odd;

    assign par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign par_odd = (parity_mode == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            os      <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            state   <= state_n;
            os      <= os_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            perr    <= perr_n;
            armed   <= armed_n;
        end
    end

    // armed gates new starts: it needs a high line on a tick, so a break
    // (stop read low and line held low) cannot retrigger a frame.
    always_comb begin
        state_n = state;
        os_n    = os;
        bit_n   = bit_cnt;
        shift_n = shift;
        perr_n  = perr;
        armed_n = armed;
        wr_en   = 1'b0;
        wr_word = {perr, 1'b0, shift};
        if (tick) begin
            case (state)
                IDLE: begin
                    os_n = '0;
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                    end
                end
                START: begin
                    if (os >= OS_HALF) begin
                        os_n    = '0;
                        bit_n   = '0;
                        perr_n  = 1'b0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        os_n = os + 1'b1;
                    end
                end
                DATA: begin
                    if (os >= OS_LAST) begin
                        os_n    = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt >= BIT_LAST) begin
                            state_n = par_en ? PARITY : STOP;
                        end
                    end else begin
                        os_n = os + 1'b1;
                    end
                end
                PARITY: begin
                    if (os >= OS_LAST) begin
                        os_n    = '0;
                        perr_n  = (^shift) ^ rx_s ^ par_odd;
                        state_n = STOP;
                    end else begin
                        os_n = os + 1'b1;
                    end
                end
                STOP: begin
                    if (os >= OS_LAST) begin
                        os_n    = '0;
                        wr_en   = 1'b1;
                        wr_word = {perr, ~rx_s, shift};
                        armed_n = rx_s;
                        state_n = IDLE;
                    end else begin
                        os_n = os + 1'b1;
                    end
                end
                default: begin
                    os_n    = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              pop, push, drop, full;
    logic [WORD_W-1:0] head;

    assign full = (count == FULL_CNT);
    assign pop  = rd_en && (count != '0);
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign rx_data    = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign frame_err  = rx_valid & head[DATA_BITS];
    assign parity_err = rx_valid & head[DATA_BITS+1];
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: drives serial frames, queues the expected
// words and compares them against the FIFO head as they are popped.
module tb_uart_rx_param;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int DIV_WIDTH  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rx;
    logic [DIV_WIDTH-1:0] baud_div;
    logic [1:0]           parity_mode;
    logic                 rd_en;
    logic                 clr_ovr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic [3:0]           fifo_count;

    int compared   = 0;
    int mismatched = 0;
    int bit_clks   = 16;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS(DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_WIDTH(DIV_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .baud_div(baud_div),
        .parity_mode(parity_mode),
        .rd_en(rd_en),
        .clr_ovr(clr_ovr),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun(overrun),
        .fifo_count(fifo_count)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic has_par,
                                  input logic pbit, input logic stop_bit);
        drive_bit(1'b0, bit_clks);
        for (int i = 0; i < DATA_BITS; i++) begin
            drive_bit(d[i], bit_clks);
        end
        if (has_par) begin
            drive_bit(pbit, bit_clks);
        end
        drive_bit(stop_bit, bit_clks);
    endtask

    task automatic send_good(input logic [7:0] d, input logic has_par,
                             input logic pbit, input logic exp_perr);
        sb.push_back({exp_perr, 1'b0, d});
        apply_stimulus(d, has_par, pbit, 1'b1);
        drive_bit(1'b1, 2 * bit_clks);
    endtask

    task automatic read_word(input string tag);
        logic [9:0] exp;
        int n;
        n = 0;
        while (!rx_valid && n < 64 * bit_clks) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_valid"}, 32'(rx_valid), 32'd1);
        check_output({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 10'h0;
        check_output({tag, "_data"}, 32'(rx_data), 32'(exp[7:0]));
        check_output({tag, "_ferr"}, 32'(frame_err), 32'(exp[8]));
        check_output({tag, "_perr"}, 32'(parity_err), 32'(exp[9]));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        baud_div = '0;
        parity_mode = 2'b00;
        rd_en = 1'b0;
        clr_ovr = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_valid", 32'(rx_valid), 32'd0);
        check_output("rst_data", 32'(rx_data), 32'd0);
        check_output("rst_count", 32'(fifo_count), 32'd0);
        check_output("rst_ovr", 32'(overrun), 32'd0);
        check_output("rst_ferr", 32'(frame_err), 32'd0);
        check_output("rst_perr", 32'(parity_err), 32'd0);
        drive_bit(1'b1, 32);

        $display("[TB] basic frame 0xA5, no parity");
        send_good(8'hA5, 1'b0, 1'b0, 1'b0);
        check_output("a5_count", 32'(fifo_count), 32'd1);
        read_word("a5");
        check_output("a5_count_after", 32'(fifo_count), 32'd0);
        check_output("empty_data", 32'(rx_data), 32'd0);

        $display("[TB] parity frames");
        parity_mode = 2'b01;
        send_good(8'h03, 1'b1, 1'b1, 1'b1);
        send_good(8'h03, 1'b1, 1'b0, 1'b0);
        parity_mode = 2'b10;
        send_good(8'h07, 1'b1, 1'b0, 1'b0);
        send_good(8'h07, 1'b1, 1'b1, 1'b1);
        check_output("par_count", 32'(fifo_count), 32'd4);
        repeat (4) read_word("par");
        parity_mode = 2'b00;

        $display("[TB] slower baud divisor");
        baud_div = 16'd2;
        bit_clks = 48;
        send_good(8'hC3, 1'b0, 1'b0, 1'b0);
        read_word("div2");
        baud_div = '0;
        bit_clks = 16;

        $display("[TB] frame error with break");
        sb.push_back({1'b0, 1'b1, 8'h55});
        apply_stimulus(8'h55, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 3 * bit_clks);
        check_output("brk_count_low", 32'(fifo_count), 32'd1);
        drive_bit(1'b1, 3 * bit_clks);
        check_output("brk_count_high", 32'(fifo_count), 32'd1);
        read_word("brk");

        $display("[TB] start glitch");
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        check_output("glitch_count", 32'(fifo_count), 32'd0);

        $display("[TB] overrun");
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                send_good(8'(8'h11 * i + 8'h01), 1'b0, 1'b0, 1'b0);
            end else begin
                apply_stimulus(8'hEE, 1'b0, 1'b0, 1'b1);
                drive_bit(1'b1, 2 * bit_clks);
            end
        end
        check_output("ovr_count", 32'(fifo_count), 32'd8);
        check_output("ovr_flag", 32'(overrun), 32'd1);
        repeat (8) read_word("ovr");
        check_output("ovr_drained", 32'(fifo_count), 32'd0);
        check_output("ovr_sticky", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        check_output("ovr_cleared", 32'(overrun), 32'd0);

        $display("[TB] reset mid-frame");
        apply_stimulus(8'hE7, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b1, 2 * bit_clks);
        check_output("mid_pre_count", 32'(fifo_count), 32'd1);
        drive_bit(1'b0, bit_clks);
        for (int i = 0; i < 5; i++) begin
            drive_bit(i[0], bit_clks);
        end
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("mid_valid", 32'(rx_valid), 32'd0);
        check_output("mid_data", 32'(rx_data), 32'd0);
        check_output("mid_count", 32'(fifo_count), 32'd0);
        check_output("mid_ferr", 32'(frame_err), 32'd0);
        check_output("mid_perr", 32'(parity_err), 32'd0);
        check_output("mid_ovr", 32'(overrun), 32'd0);
        drive_bit(1'b1, 32);
        send_good(8'h3C, 1'b0, 1'b0, 1'b0);
        read_word("post_rst");

        check_output("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
